// File: rtl/fetch_decode_pipe_pkg.sv
// Shared constants and pipeline-register types for the fetch/decode boundary.
package fetch_decode_pipe_pkg;

   localparam int          ADDR_W_DEFAULT   = 32;
   localparam int          INST_W_DEFAULT   = 32;
   localparam int          CNT_W_DEFAULT    = 8;
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [ADDR_W_DEFAULT-1:0] addr;
      logic [INST_W_DEFAULT-1:0] inst;
   } fd_entry_t;

   // A single-entry buffer still needs a 1-bit pointer to index storage.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Fetch-side and decode-side handshake bundle between fetch and decode.
interface fetch_decode_pipe_if
   import fetch_decode_pipe_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int INST_W = INST_W_DEFAULT
);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [INST_W-1:0] in_inst;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [INST_W-1:0] out_inst;

   modport master (
      output in_valid, in_addr, in_inst, stall, flush,
      input  in_ready, out_valid, out_addr, out_inst
   );

   modport slave (
      input  in_valid, in_addr, in_inst, stall, flush,
      output in_ready, out_valid, out_addr, out_inst
   );

endinterface

// File: rtl/fetch_decode_pipe_sat_counter.sv
// Saturating accumulator: adds inc when en is high and sticks at all-ones.
module sat_counter #(
   parameter int W     = 8,
   parameter int INC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [INC_W-1:0] inc,
   output logic [W-1:0]     count
);

   localparam int               SUM_W = ((W > INC_W) ? W : INC_W) + 1;
   localparam logic [SUM_W-1:0] MAX   = {{(SUM_W - W){1'b0}}, {W{1'b1}}};

   logic [SUM_W-1:0] sum;

   assign sum = SUM_W'(count) + SUM_W'(inc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en) begin
         count <= (sum > MAX) ? '1 : sum[W-1:0];
      end
   end

endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch-to-decode skid buffer: DEPTH-entry circular queue with stall, flush and a
// saturating count of entries discarded by flush.
module fetch_decode_pipe
   import fetch_decode_pipe_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEFAULT,
   parameter int                INST_W   = INST_W_DEFAULT,
   parameter int                DEPTH    = 2,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT),
   parameter int                CNT_W    = CNT_W_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   fetch_decode_pipe_if.slave           bus,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [CNT_W-1:0]             squash_cnt
);

   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int PTR_W = ptr_width(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              push;
   logic              pop;
   logic [LVL_W:0]    squash_inc;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // in_ready looks only at registered occupancy so fetch never sees a comb path from decode.
   assign bus.in_ready  = (level < LVL_W'(DEPTH));
   assign bus.out_valid = (level != '0);
   assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr] : '0;
   assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr] : NOP_INST;

   assign push = bus.in_valid && bus.in_ready && !bus.flush;
   assign pop  = bus.out_valid && !bus.stall && !bus.flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            level <= level + LVL_W'(1);
         end else if (pop && !push) begin
            level <= level - LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= bus.in_addr;
         inst_mem[wr_ptr] <= bus.in_inst;
      end
   end

   // A flush discards everything held plus the beat that would have been accepted.
   assign squash_inc = {1'b0, level} + {{LVL_W{1'b0}}, (bus.in_valid && bus.in_ready)};

   sat_counter #(
      .W     (CNT_W),
      .INC_W (LVL_W + 1)
   ) u_squash_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.flush),
      .inc   (squash_inc),
      .count (squash_cnt)
   );

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: a DEPTH=2/CNT_W=8 and a DEPTH=3/CNT_W=2 instance share
// stimulus and are both compared every cycle against a list-based reference model.
module tb_fetch_decode_pipe;
   import fetch_decode_pipe_pkg::*;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] INST_KEY = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_inst = '0;

   logic [1:0]  level_a;
   logic [1:0]  level_b;
   logic [7:0]  squash_a;
   logic [1:0]  squash_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_decode_pipe_if #(.ADDR_W(32), .INST_W(32)) bus_a ();
   fetch_decode_pipe_if #(.ADDR_W(32), .INST_W(32)) bus_b ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_addr  = in_addr;
   assign bus_a.in_inst  = in_inst;
   assign bus_a.stall    = stall;
   assign bus_a.flush    = flush;
   assign bus_b.in_valid = in_valid;
   assign bus_b.in_addr  = in_addr;
   assign bus_b.in_inst  = in_inst;
   assign bus_b.stall    = stall;
   assign bus_b.flush    = flush;

   fetch_decode_pipe #(.DEPTH(2)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_a),
      .level      (level_a),
      .squash_cnt (squash_a)
   );

   fetch_decode_pipe #(.DEPTH(3), .CNT_W(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_b),
      .level      (level_b),
      .squash_cnt (squash_b)
   );

   // Reference model: each instance is an ordered list whose element 0 is the head.
   logic [31:0] m_addr [2][8];
   logic [31:0] m_inst [2][8];
   int          m_cnt  [2];
   int          m_sq   [2];

   function automatic int depth_of(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int sat_max(input int d);
      return (d == 0) ? 255 : 3;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0;
         m_sq[d]  = 0;
      end
   endtask

   task automatic modelEdge();
      for (int d = 0; d < 2; d++) begin
         int accept;
         accept = (in_valid && (m_cnt[d] < depth_of(d))) ? 1 : 0;
         if (flush) begin
            m_sq[d] = m_sq[d] + m_cnt[d] + accept;
            if (m_sq[d] > sat_max(d)) m_sq[d] = sat_max(d);
            m_cnt[d] = 0;
         end else begin
            if (m_cnt[d] > 0 && !stall) begin
               for (int i = 0; i < 7; i++) begin
                  m_addr[d][i] = m_addr[d][i+1];
                  m_inst[d][i] = m_inst[d][i+1];
               end
               m_cnt[d] = m_cnt[d] - 1;
            end
            if (accept == 1) begin
               m_addr[d][m_cnt[d]] = in_addr;
               m_inst[d][m_cnt[d]] = in_inst;
               m_cnt[d] = m_cnt[d] + 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   task automatic checkOutput();
      for (int d = 0; d < 2; d++) begin
         logic        ov;
         logic        rdy;
         logic [31:0] oa;
         logic [31:0] oi;
         int          lv;
         int          sq;
         if (d == 0) begin
            ov = bus_a.out_valid; rdy = bus_a.in_ready; oa = bus_a.out_addr; oi = bus_a.out_inst;
            lv = int'(level_a);   sq = int'(squash_a);
         end else begin
            ov = bus_b.out_valid; rdy = bus_b.in_ready; oa = bus_b.out_addr; oi = bus_b.out_inst;
            lv = int'(level_b);   sq = int'(squash_b);
         end
         check($sformatf("d%0d out_valid", d), 64'(ov), 64'(m_cnt[d] != 0));
         check($sformatf("d%0d out_addr", d), 64'(oa), 64'((m_cnt[d] != 0) ? m_addr[d][0] : 32'h0));
         check($sformatf("d%0d out_inst", d), 64'(oi), 64'((m_cnt[d] != 0) ? m_inst[d][0] : NOP));
         check($sformatf("d%0d level", d), 64'(lv), 64'(m_cnt[d]));
         check($sformatf("d%0d in_ready", d), 64'(rdy), 64'(m_cnt[d] < depth_of(d)));
         check($sformatf("d%0d squash_cnt", d), 64'(sq), 64'(m_sq[d]));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic s, input logic f);
      in_valid = v;
      in_addr  = a;
      in_inst  = a ^ INST_KEY;
      stall    = s;
      flush    = f;
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   typedef struct {
      logic        valid;
      logic [31:0] addr;
      logic        stall;
      logic        flush;
      int          exp_level;
      logic [31:0] exp_addr;
      int          exp_squash;
   } vec_t;

   vec_t vecs [17];

   initial begin
      // Expected columns describe the DEPTH=2 instance after the edge.
      vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1, 32'h100, 0};
      vecs[1]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1, 32'h104, 0};
      vecs[2]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1, 32'h108, 0};
      vecs[3]  = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 32'h000, 0};
      vecs[4]  = '{1'b1, 32'h200, 1'b1, 1'b0, 1, 32'h200, 0};
      vecs[5]  = '{1'b1, 32'h204, 1'b1, 1'b0, 2, 32'h200, 0};
      vecs[6]  = '{1'b1, 32'h208, 1'b1, 1'b0, 2, 32'h200, 0};
      vecs[7]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1, 32'h204, 0};
      vecs[8]  = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 32'h000, 0};
      vecs[9]  = '{1'b1, 32'h300, 1'b1, 1'b0, 1, 32'h300, 0};
      vecs[10] = '{1'b1, 32'h304, 1'b1, 1'b0, 2, 32'h300, 0};
      vecs[11] = '{1'b1, 32'h308, 1'b1, 1'b1, 0, 32'h000, 2};
      vecs[12] = '{1'b1, 32'h400, 1'b1, 1'b0, 1, 32'h400, 2};
      vecs[13] = '{1'b0, 32'h000, 1'b1, 1'b1, 0, 32'h000, 3};
      vecs[14] = '{1'b0, 32'h000, 1'b0, 1'b1, 0, 32'h000, 3};
      vecs[15] = '{1'b1, 32'h500, 1'b0, 1'b0, 1, 32'h500, 3};
      vecs[16] = '{1'b0, 32'h000, 1'b0, 1'b0, 0, 32'h000, 3};

      modelReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      #1 checkOutput();
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].stall, vecs[i].flush);
         tick();
         check($sformatf("vec%0d level", i), 64'(level_a), 64'(vecs[i].exp_level));
         check($sformatf("vec%0d out_valid", i), 64'(bus_a.out_valid), 64'(vecs[i].exp_level != 0));
         check($sformatf("vec%0d out_addr", i), 64'(bus_a.out_addr), 64'(vecs[i].exp_addr));
         check($sformatf("vec%0d out_inst", i), 64'(bus_a.out_inst),
               64'((vecs[i].exp_level != 0) ? (vecs[i].exp_addr ^ INST_KEY) : NOP));
         check($sformatf("vec%0d squash", i), 64'(squash_a), 64'(vecs[i].exp_squash));
      end

      // Asynchronous reset with two entries held, observed before the next edge.
      applyStimulus(1'b1, 32'h700, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h704, 1'b1, 1'b0);
      tick();
      check("pre-reset level", 64'(level_a), 64'd2);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      #3 rst = 1'b0;
      modelReset();
      #1;
      check("reset out_valid", 64'(bus_a.out_valid), 64'd0);
      check("reset out_inst", 64'(bus_a.out_inst), 64'(NOP));
      check("reset level", 64'(level_a), 64'd0);
      check("reset in_ready", 64'(bus_a.in_ready), 64'd1);
      checkOutput();
      @(posedge clk);
      #1 rst = 1'b1;

      applyStimulus(1'b1, 32'h800, 1'b0, 1'b0);
      tick();
      check("first push after reset", 64'(bus_a.out_addr), 64'h800);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tick();

      // Two held entries plus an acceptable incoming beat on the DEPTH=3 instance.
      applyStimulus(1'b1, 32'h600, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h604, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h608, 1'b1, 1'b1);
      tick();
      check("flush b squash", 64'(squash_b), 64'd3);
      check("flush a squash", 64'(squash_a), 64'd2);
      check("flush b level", 64'(level_b), 64'd0);
      check("flush b out_inst", 64'(bus_b.out_inst), 64'(NOP));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      check("flushed beat dropped", 64'(bus_b.out_valid), 64'd0);

      // Saturation: a full DEPTH=3 buffer flushed again cannot move a 2-bit count past 3.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h610 + 32'(4 * i), 1'b1, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 32'h61C, 1'b1, 1'b1);
      tick();
      check("saturated b squash", 64'(squash_b), 64'd3);
      check("accumulated a squash", 64'(squash_a), 64'd4);

      // Pointer wrap: ten push cycles with intermittent stall, then drain.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'h900 + 32'(4 * i), (i % 3) == 0, 1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         tick();
      end

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom() & 32'hFFFF_FFFC,
                       $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
